// File: rtl/data_mem_pkg.sv
// Shared types and sizes for the store buffer and the 16-word data memory.
// Holds widths, the load FSM state enum, the FIFO entry struct and a match helper.
package data_mem_pkg;

    localparam int MEM_WORDS = 16;
    localparam int AW        = 16;
    localparam int DW        = 16;
    localparam int IDX_W     = $clog2(MEM_WORDS);
    localparam int SB_DEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_RD   = 2'd1,
        LD_WAIT = 2'd2
    } ld_state_e;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } sb_entry_t;

    // Only the memory word index takes part in a match, so addresses
    // that differ above IDX_W alias to the same word.
    function automatic logic idx_match(input logic [AW-1:0] a,
                                       input logic [AW-1:0] b);
        return a[IDX_W-1:0] == b[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store, load and memory-port signals between datapath/memory and store_buffer.
// master: datapath+memory side; slave: store_buffer.
interface store_buffer_if;
    import data_mem_pkg::*;

    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic          ld_rvalid;
    logic [DW-1:0] ld_rdata;
    logic          mem_write;
    logic          mem_read;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          sb_empty;

    modport master (
        output st_valid, st_addr, st_data,
        output ld_valid, ld_addr, mem_rdata,
        input  st_ready, ld_ready, ld_rvalid, ld_rdata,
        input  mem_write, mem_read, mem_addr, mem_wdata,
        input  sb_empty
    );

    modport slave (
        input  st_valid, st_addr, st_data,
        input  ld_valid, ld_addr, mem_rdata,
        output st_ready, ld_ready, ld_rvalid, ld_rdata,
        output mem_write, mem_read, mem_addr, mem_wdata,
        output sb_empty
    );

endinterface

// File: rtl/store_fifo.sv
// Age-ordered store FIFO: storage, head/tail pointers, count, full/empty.
// Ports: clk, reset (sync active-low), i_push/i_ent, i_pop, o_full, o_empty,
//        o_head, o_valid/o_age (entries by age, index 0 = oldest).
module store_fifo
    import data_mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  sb_entry_t              i_ent,
    input  logic                   i_pop,
    output logic                   o_full,
    output logic                   o_empty,
    output sb_entry_t              o_head,
    output logic      [DEPTH-1:0]  o_valid,
    output sb_entry_t [DEPTH-1:0]  o_age
);

    localparam int PW = $clog2(DEPTH);

    sb_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_head];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= i_ent;
                r_tail        <= r_tail + PW'(1);
            end
            if (w_pop)
                r_head <= r_head + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Pointer wrap is free because DEPTH is a power of two.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            o_age[k]   = r_mem[r_head + PW'(k)];
            o_valid[k] = ((PW+1)'(k) < r_count);
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer + single-outstanding load port in front of the data memory.
// Ports: clk, reset (sync active-low), bus (store_buffer_if.slave).
// Macro STORE_FWD_EN: defined = store-to-load forwarding; undefined = loads
// wait for an empty buffer and always read memory.
module store_buffer
    import data_mem_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input logic           clk,
    input logic           reset,
    store_buffer_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_RD   = 2'(LD_RD);
    localparam logic [1:0] S_WAIT = 2'(LD_WAIT);

    logic [1:0]              r_state;
    logic                    r_fwd;
    logic [DW-1:0]           r_fwd_data;
    logic [AW-1:0]           r_ld_addr;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_ld_acc;
    logic                    w_hit;
    logic                    w_rd;
    logic                    w_wr;
    logic [DW-1:0]           w_fwd_data;
    sb_entry_t               w_st_ent;
    sb_entry_t               w_head;
    logic      [DEPTH-1:0]   w_valid;
    sb_entry_t [DEPTH-1:0]   w_age;

    assign w_st_ent.addr = bus.st_addr;
    assign w_st_ent.data = bus.st_data;
    assign w_push        = bus.st_valid && !w_full;

    store_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_ent   (w_st_ent),
        .i_pop   (w_wr),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head),
        .o_valid (w_valid),
        .o_age   (w_age)
    );

`ifdef STORE_FWD_EN
    // Walk oldest to youngest so the last hit is the youngest store.
    // The compare sees pre-push contents, so a same-cycle store is never used.
    always_comb begin
        w_hit      = 1'b0;
        w_fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_valid[k] && idx_match(w_age[k].addr, bus.ld_addr)) begin
                w_hit      = 1'b1;
                w_fwd_data = w_age[k].data;
            end
        end
    end

    assign bus.ld_ready = (r_state == S_IDLE);
`else
    logic w_unused;

    assign w_unused     = ^{w_valid, w_age};
    assign w_hit        = 1'b0;
    assign w_fwd_data   = '0;
    assign bus.ld_ready = (r_state == S_IDLE) && w_empty;
`endif

    assign w_ld_acc = bus.ld_valid && bus.ld_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_fwd      <= 1'b0;
            r_fwd_data <= '0;
            r_ld_addr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ld_acc) begin
                        r_ld_addr  <= bus.ld_addr;
                        r_fwd      <= w_hit;
                        r_fwd_data <= w_fwd_data;
                        r_state    <= w_hit ? S_WAIT : S_RD;
                    end
                end
                S_RD:    r_state <= S_WAIT;
                S_WAIT:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Loads own the port in LD_RD; every other cycle drains the head.
    assign w_rd = (r_state == S_RD);
    assign w_wr = !w_rd && !w_empty;

    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        unique case (1'b1)
            w_rd: bus.mem_addr = r_ld_addr;
            w_wr: begin
                bus.mem_addr  = w_head.addr;
                bus.mem_wdata = w_head.data;
            end
            default: ;
        endcase
    end

    assign bus.mem_read  = w_rd;
    assign bus.mem_write = w_wr;
    assign bus.st_ready  = !w_full;
    assign bus.sb_empty  = w_empty;
    assign bus.ld_rvalid = (r_state == S_WAIT);
    assign bus.ld_rdata  = !bus.ld_rvalid ? '0 :
                           r_fwd ? r_fwd_data : bus.mem_rdata;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with load/store scoreboards and a memory model.
// Honors STORE_FWD_EN to pick expected load paths.
module tb_store_buffer;
    import data_mem_pkg::*;

`ifdef STORE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic mem_init = 1'b1;

    store_buffer_if bus();

    store_buffer #(.DEPTH(SB_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [MEM_WORDS];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < MEM_WORDS; i++)
                mem[i] <= DW'(3 * i);
            bus.mem_rdata <= '0;
        end else begin
            if (bus.mem_write)
                mem[bus.mem_addr[IDX_W-1:0]] <= bus.mem_wdata;
            if (bus.mem_read)
                bus.mem_rdata <= mem[bus.mem_addr[IDX_W-1:0]];
        end
    end

    logic [DW-1:0] lq [$];
    sb_entry_t     wq [$];
    logic [DW-1:0] ref_mem [MEM_WORDS];
    logic [DW-1:0] cm [MEM_WORDS];
    int n_cmp = 0;
    int n_err = 0;
    int n_push = 0;
    int n_wr = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && !mem_init) begin
            check("rd_wr_excl", 32'(bus.mem_read & bus.mem_write), 0);
            if (!bus.mem_read && !bus.mem_write) begin
                check("idle_addr", 32'(bus.mem_addr), 0);
                check("idle_wdata", 32'(bus.mem_wdata), 0);
            end
            if (bus.mem_write) begin
                n_wr++;
                check("wr_expected", 32'(wq.size() != 0), 1);
                if (wq.size() != 0) begin
                    sb_entry_t e;
                    e = wq.pop_front();
                    check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                    check("wr_data", 32'(bus.mem_wdata), 32'(e.data));
                    cm[e.addr[IDX_W-1:0]] = e.data;
                end
            end
            if (bus.ld_rvalid) begin
                check("rv_expected", 32'(lq.size() != 0), 1);
                if (lq.size() != 0)
                    check("ld_rdata", 32'(bus.ld_rdata), 32'(lq.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.st_valid = 1'b0;
        bus.ld_valid = 1'b0;
    endtask

    task automatic drive_st(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.st_valid = 1'b1;
        bus.st_addr  = a;
        bus.st_data  = d;
        if (bus.st_ready) begin
            sb_entry_t e;
            e.addr = a;
            e.data = d;
            wq.push_back(e);
            ref_mem[a[IDX_W-1:0]] = d;
            n_push++;
        end
    endtask

    task automatic drive_ld(input logic [AW-1:0] a);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        if (bus.ld_ready)
            lq.push_back(ref_mem[a[IDX_W-1:0]]);
    endtask

    task automatic wait_empty();
        int n = 0;
        while (!bus.sb_empty && n < 100) begin
            cyc();
            n++;
        end
        check("drain_done", 32'(bus.sb_empty), 1);
    endtask

    task automatic do_load(input logic [AW-1:0] a, input bit hit);
        int n = 0;
        while (!bus.ld_ready && n < 100) begin
            cyc();
            n++;
        end
        check("ld_accept", 32'(bus.ld_ready), 1);
        drive_ld(a);
        cyc();
        bus.ld_valid = 1'b0;
        if (hit) begin
            check("hit_lat1", 32'(bus.ld_rvalid), 1);
        end else begin
            check("miss_rd", 32'(bus.mem_read), 1);
            check("miss_addr", 32'(bus.mem_addr), 32'(a));
            check("miss_lat1", 32'(bus.ld_rvalid), 0);
            cyc();
            check("miss_lat2", 32'(bus.ld_rvalid), 1);
        end
        cyc();
    endtask

    task automatic check_reset_vals();
        check("rst_st_ready", 32'(bus.st_ready), 1);
        check("rst_ld_ready", 32'(bus.ld_ready), 1);
        check("rst_sb_empty", 32'(bus.sb_empty), 1);
        check("rst_ld_rvalid", 32'(bus.ld_rvalid), 0);
        check("rst_ld_rdata", 32'(bus.ld_rdata), 0);
        check("rst_mem_write", 32'(bus.mem_write), 0);
        check("rst_mem_read", 32'(bus.mem_read), 0);
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    endtask

    initial begin
        bit saw_full;
        bit found;
        idle();
        bus.st_addr = '0;
        bus.st_data = '0;
        bus.ld_addr = '0;
        for (int i = 0; i < MEM_WORDS; i++) begin
            ref_mem[i] = DW'(3 * i);
            cm[i]      = DW'(3 * i);
        end
        repeat (2) cyc();
        check_reset_vals();
        mem_init = 1'b0;
        reset    = 1'b1;
        cyc();
        check_reset_vals();

        // single store drains in the following cycle
        drive_st(16'h0003, 16'hBEEF);
        cyc();
        idle();
        check("t1_wr", 32'(bus.mem_write), 1);
        check("t1_addr", 32'(bus.mem_addr), 32'h0003);
        check("t1_data", 32'(bus.mem_wdata), 32'hBEEF);
        cyc();
        check("t1_empty", 32'(bus.sb_empty), 1);
        check("t1_nowr", 32'(bus.mem_write), 0);

        // two stores to one word held back by a miss load, then load it
        drive_ld(16'h0009);
        drive_st(16'h0007, 16'h7777);
        cyc();
        bus.ld_valid = 1'b0;
        check("t2_rd_block", 32'(bus.mem_read), 1);
        check("t2_wr_block", 32'(bus.mem_write), 0);
        drive_st(16'h0005, 16'h1111);
        cyc();
        drive_st(16'h0005, 16'h2222);
        cyc();
        idle();
`ifdef STORE_FWD_EN
        do_load(16'h0005, 1'b1);
`else
        check("t2_ld_wait", 32'(bus.ld_ready), 0);
        do_load(16'h0005, 1'b0);
`endif
        wait_empty();

        // plain miss on empty buffer
        do_load(16'h0002, 1'b0);

        // same-cycle store and load to one word: load sees old value
        drive_ld(16'h0006);
        drive_st(16'h0006, 16'h6666);
        cyc();
        idle();
        check("t3_miss_rd", 32'(bus.mem_read), 1);
        check("t3_lat1", 32'(bus.ld_rvalid), 0);
        cyc();
        check("t3_lat2", 32'(bus.ld_rvalid), 1);
        cyc();
        wait_empty();

        // aliasing: 0x0013 matches word 3
        drive_st(16'h0003, 16'hAAAA);
        cyc();
        idle();
        do_load(16'h0013, FWD);
        wait_empty();

        // continuous stores against miss loads: fill and refill
        saw_full = 1'b0;
        for (int c = 0; c < 40; c++) begin
            check("t4_st_ready", 32'(bus.st_ready),
                  32'((n_push - n_wr) < SB_DEPTH));
            check("t4_empty", 32'(bus.sb_empty), 32'(n_push == n_wr));
            if (!bus.st_ready)
                saw_full = 1'b1;
            drive_st(AW'(10 + (c % 4)), DW'(16'hA000 + c));
            bus.ld_valid = 1'b0;
            if (bus.ld_ready)
                drive_ld(16'h000F);
            cyc();
        end
        idle();
        check("t4_full_seen", 32'(saw_full), 32'(FWD));
        repeat (3) cyc();
        wait_empty();

        // reset while a miss load is in LD_RD with entries buffered
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (bus.mem_read &&
                (n_push - n_wr) >= (FWD ? 3 : 1)) begin
                found = 1'b1;
            end else begin
                drive_st(AW'(10 + (c % 4)), DW'(16'hC000 + c));
                bus.ld_valid = 1'b0;
                if (bus.ld_ready)
                    drive_ld(16'h000F);
                cyc();
            end
        end
        check("t6_found", 32'(found), 1);
        reset = 1'b0;
        idle();
        lq.delete();
        wq.delete();
        for (int i = 0; i < MEM_WORDS; i++)
            ref_mem[i] = cm[i];
        cyc();
        check_reset_vals();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check("t6_nowr", 32'(bus.mem_write), 0);
            check("t6_norv", 32'(bus.ld_rvalid), 0);
            cyc();
        end
        do_load(16'h000A, 1'b0);
        do_load(16'h000B, 1'b0);

        wait_empty();
        repeat (3) cyc();
        check("lq_drained", 32'(lq.size()), 0);
        check("wq_drained", 32'(wq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Store buffer and load port between the datapath's ALU/register-file outputs and the 16-word data memory. Stores are queued in a small FIFO and written to memory in idle memory cycles. Loads take priority for the memory port. Each load returns the youngest buffered store to the same word (forwarding) or the memory contents. Only one load is outstanding at a time.

## Interface
- DEPTH, 4, store entries (power of two, 2..8)
- AW, 16, address width
- DW, 16, data width
- IDX_W, 4, memory word-index bits used for matching (16-word memory)

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clk
- st_valid  in  1  store request
- st_ready  out  1  buffer can accept a store; = !full
- st_addr  in  AW  store address
- st_data  in  DW  store data
- ld_valid  in  1  load request
- ld_ready  out  1  load accepted when ld_valid & ld_ready
- ld_addr  in  AW  load address
- ld_rvalid  out  1  one-cycle pulse: ld_rdata valid
- ld_rdata  out  DW  load result
- mem_write  out  1  to memory write enable
- mem_read  out  1  to memory read enable
- mem_addr  out  AW  to memory address
- mem_wdata  out  DW  to memory write data
- mem_rdata  in  DW  from memory; valid the cycle after mem_read is high
- sb_empty  out  1  no buffered stores (fence/halt use)

## Operation
- The FIFO holds {addr, data} entries, ordered by age. Push on st_valid & st_ready. Pop when the head entry is drained.
- Load FSM has three states: IDLE, LD_RD and LD_WAIT.
  - IDLE: ld_ready = 1. On accept: compare ld_addr[IDX_W-1:0] with every valid entry's addr[IDX_W-1:0].
    - On a hit, capture the youngest matching data, then go to LD_WAIT with the forwarded flag set.
    - On a miss, go to LD_RD.
  - LD_RD: mem_read = 1 and mem_addr = the latched load address. Next state is LD_WAIT.
  - LD_WAIT: ld_rvalid = 1. ld_rdata = the forwarded data if the flag is set, else mem_rdata. Next state is IDLE.
- Drain: in any cycle where mem_read = 0 and the FIFO is non-empty, drive the head entry:
  - mem_write = 1, mem_addr = head addr, mem_wdata = head data.
  - Pop on that edge.
- mem_read and mem_write are never high together.
- Idle bus values: mem_addr and mem_wdata are 0 when neither mem_read nor mem_write is asserted.
- Full: st_ready = 0 while count == DEPTH, even if a pop is occurring that cycle. Push and pop in the same cycle are legal when not full; count is unchanged.
- Store and load accepted in the same cycle: the load compares against pre-push contents. The new store is younger and is not forwarded.
- Address wrap: only IDX_W bits are matched. Addresses differing only above bit IDX_W-1 alias to the same word.
- Reset mid-operation discards all buffered stores and any in-flight load. No ld_rvalid is issued for that load.

## Timing
- Reset values:
  - st_ready = 1, ld_ready = 1, sb_empty = 1.
  - ld_rvalid = 0, ld_rdata = 0.
  - mem_write = 0, mem_read = 0, mem_addr = 0, mem_wdata = 0.
  - FSM in IDLE, count = 0.
- Load latency from the acceptance edge:
  - Forward hit: ld_rvalid in the next cycle (1).
  - Miss: ld_rvalid in the second cycle (2).
- ld_ready = 0 in LD_RD and LD_WAIT. This gives a maximum of one load every 2 (hit) or 3 (miss) cycles.
- Store drain: a stored entry reaches mem_write no earlier than the cycle after its push.
- Throughput is one drain per cycle while no miss load occupies the bus.

## Configuration
- STORE_FWD_EN:
  - Defined: forwarding as described above.
  - Undefined:
    - No comparators. ld_ready = IDLE & sb_empty, so loads wait until the buffer fully drains.
    - Every accepted load takes the miss path with 2-cycle latency.

## Structure
- Package data_mem_pkg holds:
  - AW, DW, IDX_W and MEM_WORDS = 16.
  - The load FSM state enum (IDLE, LD_RD, LD_WAIT).
  - The entry struct {addr, data}.
- Sub-module store_fifo: storage, head/tail pointers, count, full/empty, and per-entry valid/addr outputs for the forwarding compare.
- Youngest-match selection, the FSM and the memory port mux live in store_buffer.

## Test plan
- After reset, push store 0x0003←0xBEEF, then idle: mem_write in the following cycle with addr 0x0003, data 0xBEEF. sb_empty = 1 afterwards.
- Push 0x0005←0x1111 then 0x0005←0x2222, then load 0x0005 before any drain: ld_rvalid 1 cycle after accept with 0x2222 (youngest). Without STORE_FWD_EN: ld_ready stays low until empty, then 0x2222 is returned from memory 2 cycles after accept.
- Load 0x0002 (initial content 0x0006) with an empty buffer: mem_read in cycle 1, ld_rvalid with 0x0006 in cycle 2.
- Push 5 stores back-to-back while continuous miss loads hold the bus: st_ready falls after the 4th push. The 5th store is accepted only after a drain. Check that mem_read and mem_write are never both high.
- Load 0x0013 with buffered store 0x0003←0xAAAA: aliasing hit, returns 0xAAAA.
- Assert reset in LD_RD with 3 entries buffered: the next cycle shows all reset values, no ld_rvalid, and no mem_write of the discarded entries.
